// File: rtl/sad_min_search.sv
// Best-candidate tracker for integer motion estimation: keeps the per-partition
// running minimum SAD and the index of the candidate that produced it.
module sad_min_search #(
  parameter int NUM_CH   = 4,
  parameter int SAD_W    = 16,
  parameter int NUM_CAND = 1024,
  localparam int IDX_W   = $clog2(NUM_CAND)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    sad_valid,
  input  logic [NUM_CH*SAD_W-1:0] sad_in,
  output logic                    busy,
  output logic                    done,
  output logic [NUM_CH*SAD_W-1:0] min_sad,
  output logic [NUM_CH*IDX_W-1:0] min_idx
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t                         state_q, state_d;
  logic [IDX_W-1:0]               cnt_q, cnt_d;
  logic                           first_q, first_d;
  logic [NUM_CH-1:0][SAD_W-1:0]   min_sad_q, min_sad_d;
  logic [NUM_CH-1:0][IDX_W-1:0]   min_idx_q, min_idx_d;
  logic                           busy_q, busy_d;
  logic                           done_q, done_d;

  // Next-state, counter and per-lane minimum update
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    first_d   = first_q;
    min_sad_d = min_sad_q;
    min_idx_d = min_idx_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cnt_d   = {IDX_W{1'b0}};
          first_d = 1'b1;
          state_d = ST_SEARCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEARCH: begin
        // start wins over a coincident sample: the window restarts and the sample is dropped
        if (start) begin
          cnt_d   = {IDX_W{1'b0}};
          first_d = 1'b1;
          state_d = ST_SEARCH;
        end else if (sad_valid) begin
          first_d = 1'b0;
          cnt_d   = cnt_q + IDX_W'(1);
          for (int c = 0; c < NUM_CH; c++) begin
            if (first_q || (sad_in[c*SAD_W +: SAD_W] < min_sad_q[c])) begin
              min_sad_d[c] = sad_in[c*SAD_W +: SAD_W];
              min_idx_d[c] = first_q ? {IDX_W{1'b0}} : cnt_q;
            end else begin
              min_sad_d[c] = min_sad_q[c];
              min_idx_d[c] = min_idx_q[c];
            end
          end
          if (cnt_q == IDX_W'(NUM_CAND - 1)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_SEARCH;
          end
        end else begin
          state_d = ST_SEARCH;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_SEARCH);
    done_d = (state_d == ST_DONE);
  end

  // State and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= {IDX_W{1'b0}};
      first_q   <= 1'b0;
      min_sad_q <= {NUM_CH{{SAD_W{1'b1}}}};
      min_idx_q <= {NUM_CH{{IDX_W{1'b0}}}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      first_q   <= first_d;
      min_sad_q <= min_sad_d;
      min_idx_q <= min_idx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign min_sad = min_sad_q;
  assign min_idx = min_idx_q;

endmodule

// File: tb/tb_sad_min_search.sv
// Randomized and directed bench for sad_min_search, checked against a window
// model that picks the first occurrence of each lane's smallest SAD.
module tb_sad_min_search;

  localparam int NUM_CH   = 4;
  localparam int SAD_W    = 16;
  localparam int NUM_CAND = 8;
  localparam int IDX_W    = 3;
  localparam int DW       = NUM_CH * SAD_W;
  localparam int IW       = NUM_CH * IDX_W;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          sad_valid;
  logic [DW-1:0] sad_in;
  logic          busy;
  logic          done;
  logic [DW-1:0] min_sad;
  logic [IW-1:0] min_idx;

  int n_checks = 0;
  int n_pass   = 0;

  logic [DW-1:0] win_q[$];
  logic [DW-1:0] exp_sad;
  logic [IW-1:0] exp_idx;

  always #5 clk = ~clk;

  sad_min_search #(
    .NUM_CH  (NUM_CH),
    .SAD_W   (SAD_W),
    .NUM_CAND(NUM_CAND)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .sad_valid(sad_valid),
    .sad_in   (sad_in),
    .busy     (busy),
    .done     (done),
    .min_sad  (min_sad),
    .min_idx  (min_idx)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] pack4(input logic [15:0] l0, input logic [15:0] l1,
                                          input logic [15:0] l2, input logic [15:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  // Lane winner = first occurrence of the smallest value seen in this window
  task automatic model_eval();
    if (win_q.size() != 0) begin
      for (int c = 0; c < NUM_CH; c++) begin
        int best_k = 0;
        for (int k = 1; k < win_q.size(); k++) begin
          if (win_q[k][c*SAD_W +: SAD_W] < win_q[best_k][c*SAD_W +: SAD_W]) best_k = k;
        end
        exp_sad[c*SAD_W +: SAD_W] = win_q[best_k][c*SAD_W +: SAD_W];
        exp_idx[c*IDX_W +: IDX_W] = IDX_W'(best_k);
      end
    end else begin
      exp_sad = exp_sad;
    end
  endtask

  task automatic model_reset();
    win_q.delete();
    exp_sad = {DW{1'b1}};
    exp_idx = {IW{1'b0}};
  endtask

  task automatic check_results(input string tag);
    check_eq({tag, "_min_sad"}, 64'(min_sad), 64'(exp_sad));
    check_eq({tag, "_min_idx"}, 64'(min_idx), 64'(exp_idx));
  endtask

  task automatic begin_window(input string tag);
    start = 1'b1;
    tick();
    start = 1'b0;
    win_q.delete();
    check_eq({tag, "_start_busy"}, 64'(busy), 64'd1);
    check_eq({tag, "_start_done"}, 64'(done), 64'd0);
  endtask

  task automatic send(input string tag, input logic [DW-1:0] v, input bit last);
    sad_valid = 1'b1;
    sad_in    = v;
    tick();
    sad_valid = 1'b0;
    sad_in    = {$urandom, $urandom};
    win_q.push_back(v);
    model_eval();
    check_results(tag);
    check_eq({tag, "_busy"}, 64'(busy), last ? 64'd0 : 64'd1);
    check_eq({tag, "_done"}, 64'(done), last ? 64'd1 : 64'd0);
  endtask

  task automatic gap(input string tag);
    sad_valid = 1'b0;
    sad_in    = {$urandom, $urandom};
    tick();
    check_results({tag, "_gap"});
    check_eq({tag, "_gap_busy"}, 64'(busy), 64'd1);
  endtask

  task automatic finish_window(input string tag, input bit start_in_done);
    start = start_in_done;
    tick();
    start = 1'b0;
    check_eq({tag, "_post_done"}, 64'(done), 64'd0);
    check_eq({tag, "_post_busy"}, 64'(busy), 64'd0);
    check_results({tag, "_hold"});
  endtask

  // gap_mode: 0 back-to-back, 1 alternate valid/idle, 2 random gaps
  task automatic run_window(input string tag, input logic [DW-1:0] s [NUM_CAND],
                            input int gap_mode, input bit start_in_done);
    begin_window(tag);
    for (int k = 0; k < NUM_CAND; k++) begin
      send(tag, s[k], k == NUM_CAND - 1);
      if (k < NUM_CAND - 1) begin
        if (gap_mode == 1) gap(tag);
        else if (gap_mode == 2 && $urandom_range(0, 3) == 0) gap(tag);
      end
    end
    finish_window(tag, start_in_done);
  endtask

  logic [DW-1:0] s [NUM_CAND];
  logic [15:0]   lane0_basic [NUM_CAND] = '{16'd50, 16'd40, 16'd30, 16'd60, 16'd30, 16'd10, 16'd70, 16'd20};
  logic [15:0]   lane2_tie   [NUM_CAND] = '{16'd5, 16'd5, 16'd3, 16'd3, 16'd3, 16'd9, 16'd9, 16'd9};

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    sad_valid = 1'b0;
    sad_in    = {DW{1'b0}};
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_busy", 64'(busy), 64'd0);
    check_eq("reset_done", 64'(done), 64'd0);
    check_results("reset");
    rst_n = 1'b1;
    tick();

    // Basic window plus tie/first-load lanes, with start pulsed during DONE
    for (int k = 0; k < NUM_CAND; k++)
      s[k] = pack4(lane0_basic[k], 16'hFFFF, lane2_tie[k], 16'(100 - k));
    run_window("basic", s, 0, 1'b1);
    check_eq("basic_lane0_sad", 64'(min_sad[15:0]), 64'd10);
    check_eq("basic_lane0_idx", 64'(min_idx[2:0]), 64'd5);
    check_eq("tie_lane1_sad", 64'(min_sad[31:16]), 64'hFFFF);
    check_eq("tie_lane1_idx", 64'(min_idx[5:3]), 64'd0);
    check_eq("tie_lane2_sad", 64'(min_sad[47:32]), 64'd3);
    check_eq("tie_lane2_idx", 64'(min_idx[8:6]), 64'd2);

    // sad_valid in IDLE is ignored
    sad_valid = 1'b1;
    sad_in    = pack4(16'd1, 16'd1, 16'd1, 16'd1);
    tick();
    sad_valid = 1'b0;
    check_results("idle_ignore");
    check_eq("idle_ignore_busy", 64'(busy), 64'd0);

    // Gaps and lane independence: minima at indices 7, 0, 3, 6
    for (int k = 0; k < NUM_CAND; k++)
      s[k] = pack4((k == 7) ? 16'd5 : 16'd100, (k == 0) ? 16'd5 : 16'd100,
                   (k == 3) ? 16'd5 : 16'd100, (k == 6) ? 16'd5 : 16'd100);
    run_window("gaps", s, 1, 1'b0);
    check_eq("gaps_idx", 64'(min_idx), 64'({3'd6, 3'd3, 3'd0, 3'd7}));

    // Abort with a coincident zero sample that must be dropped
    begin_window("abort");
    for (int k = 0; k < 4; k++)
      send("abort_pre", pack4(16'(200 + k), 16'(300 - k), 16'(50), 16'(7 * k + 20)), 1'b0);
    start     = 1'b1;
    sad_valid = 1'b1;
    sad_in    = {DW{1'b0}};
    tick();
    start     = 1'b0;
    sad_valid = 1'b0;
    win_q.delete();
    check_results("abort_drop");
    check_eq("abort_busy", 64'(busy), 64'd1);
    for (int k = 0; k < NUM_CAND; k++)
      send("abort_post", pack4(16'd100, 16'd100, 16'd100, 16'd100), k == NUM_CAND - 1);
    finish_window("abort", 1'b0);
    check_eq("abort_final_sad", 64'(min_sad), 64'({16'd100, 16'd100, 16'd100, 16'd100}));
    check_eq("abort_final_idx", 64'(min_idx), 64'd0);

    // Reset mid-window
    begin_window("rstmid");
    for (int k = 0; k < 3; k++)
      send("rstmid_pre", pack4(16'(k + 1), 16'(k + 2), 16'(k + 3), 16'(k + 4)), 1'b0);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_results("rstmid_async");
    check_eq("rstmid_busy", 64'(busy), 64'd0);
    check_eq("rstmid_done", 64'(done), 64'd0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq("rstmid_no_done", 64'(done), 64'd0);
    end
    for (int k = 0; k < NUM_CAND; k++)
      s[k] = pack4(16'($urandom_range(0, 30)), 16'($urandom_range(0, 30)),
                   16'($urandom_range(0, 30)), 16'($urandom_range(0, 30)));
    run_window("rstmid_full", s, 0, 1'b0);

    // Randomized windows with occasional aborts and random gaps
    for (int w = 0; w < 25; w++) begin
      if ($urandom_range(0, 3) == 0) begin
        begin_window("rand_abort");
        for (int k = 0; k < int'($urandom_range(1, 6)); k++)
          send("rand_abort_pre", {$urandom, $urandom}, 1'b0);
        start     = 1'b1;
        sad_valid = $urandom_range(0, 1) == 1;
        sad_in    = {DW{1'b0}};
        tick();
        start     = 1'b0;
        sad_valid = 1'b0;
        win_q.delete();
        check_results("rand_abort_drop");
        for (int k = 0; k < NUM_CAND; k++) begin
          send("rand_abort_post", pack4(16'($urandom_range(0, 12)), 16'($urandom_range(0, 12)),
                                        16'($urandom_range(0, 12)), 16'hFFFF), k == NUM_CAND - 1);
          if (k < NUM_CAND - 1 && $urandom_range(0, 2) == 0) gap("rand_abort");
        end
        finish_window("rand_abort", 1'b0);
      end else begin
        for (int k = 0; k < NUM_CAND; k++)
          s[k] = pack4(16'($urandom_range(0, 12)), 16'($urandom_range(0, 12)),
                       ($urandom_range(0, 4) == 0) ? 16'hFFFF : 16'($urandom),
                       16'($urandom_range(65530, 65535)));
        run_window("rand", s, 2, $urandom_range(0, 1) == 1);
      end
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
